// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates a single byte-wide RAM port between an instruction
// fetch requester and a data load/store requester, one transaction at a time.
//   clk, rst            : clock, synchronous active-high reset
//   if_*                : fetch request/address/flush in, done pulse + instruction out
//   dm_*                : data request (load/store, width, sign, address, wdata) in,
//                         done pulse + load result out
//   ram_*               : byte address, write strobe, write byte out; read byte in
//                         (read byte valid one cycle after its address)
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_done_o,
  output logic [31:0] if_inst_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [1:0]  dm_width_i,
  input  logic        dm_signed_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_done_o,
  output logic [31:0] dm_rdata_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i
);

  typedef enum logic [1:0] {IDLE, IF_RD, DM_RD, DM_WR} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;        // byte slot of the current transaction
  logic [2:0]  nbytes;     // bytes in the current transaction (1/2/4)
  logic [1:0]  width;
  logic        sgn;
  logic [23:0] rbuf;       // bytes 0..2 captured so far
  logic [23:0] wbuf;       // store bytes 1..3 still to be written

  logic        accept_dm, accept_if, rd_last, wr_last, abort;
  logic [2:0]  dm_bytes;
  logic [31:0] load_val;

  always_comb begin
    case (dm_width_i)
      2'b00:   dm_bytes = 3'd1;
      2'b01:   dm_bytes = 3'd2;
      default: dm_bytes = 3'd4;
    endcase
  end

  // Final load value: the last byte arrives on ram_din_i in the completing
  // cycle, so it is merged here rather than taken from rbuf.
  always_comb begin
    case (width)
      2'b00:   load_val = {{24{sgn & ram_din_i[7]}}, ram_din_i};
      2'b01:   load_val = {{16{sgn & ram_din_i[7]}}, ram_din_i, rbuf[7:0]};
      default: load_val = {ram_din_i, rbuf};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Reads stay busy for N+1 cycles (N address slots plus one for the last
  // byte to come back); writes for N cycles.
  always_comb begin
    state_nxt = state;
    accept_dm = 1'b0;
    accept_if = 1'b0;
    rd_last   = 1'b0;
    wr_last   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req_i) begin
          accept_dm = 1'b1;
          state_nxt = dm_we_i ? DM_WR : DM_RD;
        end else if (if_req_i && !if_flush_i) begin
          accept_if = 1'b1;
          state_nxt = IF_RD;
        end
      end
      IF_RD: begin
        if (if_flush_i) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == nbytes) begin
          rd_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DM_RD: begin
        if (cnt == nbytes) begin
          rd_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DM_WR: begin
        if (cnt == nbytes - 3'd1) begin
          wr_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 3'd0;
      nbytes     <= 3'd0;
      width      <= 2'd0;
      sgn        <= 1'b0;
      rbuf       <= 24'd0;
      wbuf       <= 24'd0;
      if_done_o  <= 1'b0;
      dm_done_o  <= 1'b0;
      if_inst_o  <= 32'd0;
      dm_rdata_o <= 32'd0;
      ram_addr_o <= 32'd0;
      ram_wr_o   <= 1'b0;
      ram_dout_o <= 8'd0;
    end else begin
      if_done_o <= 1'b0;
      dm_done_o <= 1'b0;
      ram_wr_o  <= 1'b0;
      if (accept_dm || accept_if) begin
        cnt        <= 3'd0;
        ram_addr_o <= accept_dm ? dm_addr_i : if_addr_i;
        nbytes     <= accept_dm ? dm_bytes : 3'd4;
        width      <= accept_dm ? dm_width_i : 2'b10;
        sgn        <= accept_dm & dm_signed_i;
        if (accept_dm && dm_we_i) begin
          ram_wr_o   <= 1'b1;
          ram_dout_o <= dm_wdata_i[7:0];
          wbuf       <= dm_wdata_i[31:8];
        end
      end else if (state != IDLE) begin
        cnt <= cnt + 3'd1;
        // Address stops at the last byte and then holds while idle.
        if (!abort && (cnt < nbytes - 3'd1))
          ram_addr_o <= ram_addr_o + 32'd1;
        if (state == DM_WR) begin
          if (wr_last) begin
            dm_done_o <= 1'b1;
          end else begin
            ram_wr_o   <= 1'b1;
            ram_dout_o <= wbuf[7:0];
            wbuf       <= {8'd0, wbuf[23:8]};
          end
        end else begin
          // Byte cnt-1 is on ram_din_i while cnt is in 1..N.
          case (cnt)
            3'd1:    rbuf[7:0]   <= ram_din_i;
            3'd2:    rbuf[15:8]  <= ram_din_i;
            3'd3:    rbuf[23:16] <= ram_din_i;
            default: ;
          endcase
          if (rd_last) begin
            if (state == IF_RD) begin
              if_inst_o <= {ram_din_i, rbuf};
              if_done_o <= 1'b1;
            end else begin
              dm_rdata_o <= load_val;
              dm_done_o  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_flush_i, dm_req_i, dm_we_i, dm_signed_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
  logic [1:0]  dm_width_i;
  logic        if_done_o, dm_done_o, ram_wr_o;
  logic [31:0] if_inst_o, dm_rdata_o, ram_addr_o;
  logic [7:0]  ram_dout_o, ram_din_i;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_done_o(if_done_o), .if_inst_o(if_inst_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_width_i(dm_width_i),
    .dm_signed_i(dm_signed_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  // RAM model: 1 KiB aliased over the address space, registered read.
  logic [7:0] mem [0:1023];
  logic       bd_we = 1'b0;
  logic [9:0] bd_addr = 10'd0;
  logic [7:0] bd_dat = 8'd0;
  always @(posedge clk) begin
    if (ram_wr_o)   mem[ram_addr_o[9:0]] <= ram_dout_o;
    else if (bd_we) mem[bd_addr] <= bd_dat;
    ram_din_i <= mem[ram_addr_o[9:0]];
  end

  int wr_count = 0, if_cnt = 0, dm_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (ram_wr_o) wr_count++;
    if (if_done_o) if_cnt++;
    if (dm_done_o) dm_cnt++;
    if (if_done_o && dm_done_o) both_cnt++;
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    bd_addr = a; bd_dat = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic        is_if;
    logic        we;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [17];
  logic [31:0] last_load = 32'd0;
  int          exp_if = 0, exp_dm = 0;

  task automatic run_vec(input int idx, input vec_t v);
    int n, done_j, wr_before;
    logic [31:0] tmp;
    string tag;
    tag = $sformatf("v%0d", idx);
    n = v.is_if ? 4 : (v.width == 2'b00 ? 1 : (v.width == 2'b01 ? 2 : 4));
    done_j = v.we ? n + 1 : n + 2;
    wr_before = wr_count;
    if (v.is_if) begin
      if_req_i = 1'b1; if_addr_i = v.addr;
    end else begin
      dm_req_i = 1'b1; dm_we_i = v.we; dm_width_i = v.width;
      dm_signed_i = v.sgn; dm_addr_i = v.addr; dm_wdata_i = v.wdata;
    end
    for (int j = 1; j <= done_j; j++) begin
      tick();
      if (j <= n) begin
        check({tag, " addr"}, ram_addr_o, v.addr + 32'(j - 1));
        check({tag, " wr"}, {31'd0, ram_wr_o}, {31'd0, v.we});
        if (v.we) begin
          tmp = v.wdata >> (8 * (j - 1));
          check({tag, " dout"}, {24'd0, ram_dout_o}, {24'd0, tmp[7:0]});
        end
      end
      check({tag, " done"}, {31'd0, v.is_if ? if_done_o : dm_done_o}, {31'd0, j == done_j});
      check({tag, " other done"}, {31'd0, v.is_if ? dm_done_o : if_done_o}, 32'd0);
      if (j == done_j) begin
        check({tag, " idle addr"}, ram_addr_o, v.addr + 32'(n - 1));
        check({tag, " wr idle"}, {31'd0, ram_wr_o}, 32'd0);
        if (v.is_if) check({tag, " inst"}, if_inst_o, v.exp);
        else if (v.we) check({tag, " rdata hold"}, dm_rdata_o, last_load);
        else begin
          check({tag, " rdata"}, dm_rdata_o, v.exp);
          last_load = v.exp;
        end
        if_req_i = 1'b0; dm_req_i = 1'b0;
      end
    end
    check({tag, " write count"}, 32'(wr_count - wr_before), v.we ? 32'(n) : 32'd0);
    if (v.is_if) exp_if++; else exp_dm++;
  endtask

  initial begin
    int wb;
    rst = 1'b1;
    if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = 32'd0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_width_i = 2'b00; dm_signed_i = 1'b0;
    dm_addr_i = 32'd0; dm_wdata_i = 32'd0;

    //            is_if we   width  sgn   addr           wdata          exp
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0513};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_0200, 32'h0,         32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0200, 32'h0,         32'h0000_0080};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_0201, 32'h0,         32'h0000_007F};
    vecs[4]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_0300, 32'h0,         32'hFFFF_FFFE};
    vecs[5]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h0000_0300, 32'h0,         32'h0000_FFFE};
    vecs[6]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'h4433_2211};
    vecs[7]  = '{1'b0, 1'b0, 2'd3, 1'b1, 32'h0000_0100, 32'h0,         32'h0000_0513};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0007, 32'h1234_ABCD, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,         32'h00AB_CD00};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0050, 32'hDEAD_BEEF, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 2'd2, 1'b1, 32'h0000_0050, 32'h0,         32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_0051, 32'h0,         32'hFFFF_FFBE};
    vecs[13] = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h0000_0052, 32'h0,         32'h0000_DEAD};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0040, 32'h0,         32'h0010_0093};
    vecs[15] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_03FF, 32'h0000_00A5, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_03FF, 32'h0,         32'hFFFF_FFA5};

    // Preload RAM while held in reset.
    tick();
    poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'h00); poke(10'h103, 8'h00);
    poke(10'h200, 8'h80); poke(10'h201, 8'h7F);
    poke(10'h300, 8'hFE); poke(10'h301, 8'hFF);
    poke(10'h3FE, 8'h11); poke(10'h3FF, 8'h22); poke(10'h000, 8'h33); poke(10'h001, 8'h44);
    poke(10'h040, 8'h93); poke(10'h041, 8'h00); poke(10'h042, 8'h10); poke(10'h043, 8'h00);
    poke(10'h006, 8'h00); poke(10'h007, 8'h00); poke(10'h008, 8'h00); poke(10'h009, 8'h00);

    // Reset state, with requests and flush asserted to show rst dominates.
    if_req_i = 1'b1; dm_req_i = 1'b1; if_flush_i = 1'b1;
    tick(); tick();
    check("rst if_done", {31'd0, if_done_o}, 32'd0);
    check("rst dm_done", {31'd0, dm_done_o}, 32'd0);
    check("rst ram_wr", {31'd0, ram_wr_o}, 32'd0);
    check("rst if_inst", if_inst_o, 32'd0);
    check("rst dm_rdata", dm_rdata_o, 32'd0);
    check("rst ram_addr", ram_addr_o, 32'd0);
    check("rst ram_dout", {24'd0, ram_dout_o}, 32'd0);
    if_req_i = 1'b0; dm_req_i = 1'b0; if_flush_i = 1'b0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Both requests in IDLE: data first, fetch accepted in the data done cycle.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_width_i = 2'b00; dm_signed_i = 1'b1;
    dm_addr_i = 32'h200; if_req_i = 1'b1; if_addr_i = 32'h100;
    wb = wr_count;
    for (int j = 1; j <= 9; j++) begin
      tick();
      check("arb dm_done", {31'd0, dm_done_o}, {31'd0, j == 3});
      check("arb if_done", {31'd0, if_done_o}, {31'd0, j == 9});
      if (j == 3) begin
        check("arb rdata", dm_rdata_o, 32'hFFFF_FF80);
        dm_req_i = 1'b0;
      end
      if (j == 9) begin
        check("arb inst", if_inst_o, 32'h0000_0513);
        if_req_i = 1'b0;
      end
    end
    exp_if++; exp_dm++;

    // Flush in A+3 of a fetch, then refetch from 0x40 right after.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("flush if_done", {31'd0, if_done_o}, {31'd0, j == 10});
      if (j == 3) begin if_flush_i = 1'b1; if_addr_i = 32'h40; end
      if (j == 4) if_flush_i = 1'b0;
      if (j == 10) begin
        check("flush inst", if_inst_o, 32'h0010_0093);
        if_req_i = 1'b0;
      end
    end
    exp_if++;

    // Flush while idle delays fetch acceptance by one cycle.
    if_req_i = 1'b1; if_addr_i = 32'h100; if_flush_i = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j == 1) if_flush_i = 1'b0;
      check("idle flush if_done", {31'd0, if_done_o}, {31'd0, j == 7});
      if (j == 7) begin
        check("idle flush inst", if_inst_o, 32'h0000_0513);
        if_req_i = 1'b0;
      end
    end
    exp_if++;
    check("no writes in fetch seqs", 32'(wr_count - wb), 32'd0);

    // Reset in A+2 of a word store.
    wb = wr_count;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_width_i = 2'b10; dm_addr_i = 32'h60;
    dm_wdata_i = 32'hCAFE_F00D;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("mid rst ram_wr", {31'd0, ram_wr_o}, 32'd0);
    check("mid rst ram_addr", ram_addr_o, 32'd0);
    check("mid rst ram_dout", {24'd0, ram_dout_o}, 32'd0);
    check("mid rst if_inst", if_inst_o, 32'd0);
    check("mid rst dm_rdata", dm_rdata_o, 32'd0);
    check("mid rst dm_done", {31'd0, dm_done_o}, 32'd0);
    dm_req_i = 1'b0; rst = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    check("mid rst writes", 32'(wr_count - wb), 32'd2);

    check("done overlap", 32'(both_cnt), 32'd0);
    check("if_done total", 32'(if_cnt), 32'(exp_if));
    check("dm_done total", 32'(dm_cnt), 32'(exp_dm));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
